// File: rtl/sound_player.sv
// Tone sequencer for the monster-hit and spaceship-hit sound codes.
// Detects new codes, applies priority and drives the codec tone generator.
module sound_player #(
   parameter int         NOTE_TICKS          = 2500000,
   parameter int         GAP_TICKS           = 250000,
   parameter logic [3:0] MONSTER_HIT_SOUND   = 4'b0001,
   parameter logic [3:0] SPACESHIP_HIT_SOUND = 4'b1101
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] sound_signal,
   output logic [9:0] tone_freq,
   output logic       tone_enable,
   output logic       busy
);

   localparam int CW = $clog2(4 * NOTE_TICKS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_GAP
   } state_t;

   state_t          r_state;
   logic [3:0]      r_prev;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_pri;
   logic [1:0]      r_note;

   logic [1:0]      w_pri_in;
   logic            w_trig;
   logic [1:0]      w_nidx;
   logic [9:0]      w_f0_freq;
   logic [2:0]      w_f0_units;
   logic            w_cur_last;
   logic [9:0]      w_nx_freq;
   logic [2:0]      w_nx_units;

   // Priority 2 selects the spaceship table, anything else the monster table
   function automatic logic [9:0] lut_freq(input logic [1:0] pri,
                                           input logic [1:0] idx);
      logic [9:0] f;
      f = 10'd0;
      if (pri == 2'd2) begin
         case (idx)
            2'd0:    f = 10'd220;
            2'd1:    f = 10'd165;
            default: f = 10'd110;
         endcase
      end else begin
         case (idx)
            2'd0:    f = 10'd440;
            default: f = 10'd330;
         endcase
      end
      return f;
   endfunction

   function automatic logic [2:0] lut_units(input logic [1:0] pri,
                                            input logic [1:0] idx);
      logic [2:0] u;
      u = 3'd2;
      if (pri == 2'd2) begin
         case (idx)
            2'd0, 2'd1: u = 3'd3;
            default:    u = 3'd4;
         endcase
      end
      return u;
   endfunction

   function automatic logic lut_last(input logic [1:0] pri,
                                     input logic [1:0] idx);
      logic l;
      if (pri == 2'd2) l = (idx >= 2'd2);
      else             l = (idx >= 2'd1);
      return l;
   endfunction

   function automatic logic [CW-1:0] ticks(input logic [2:0] u);
      return CW'(int'(u) * NOTE_TICKS);
   endfunction

   always_comb begin
      w_pri_in = 2'd0;
      if (sound_signal == SPACESHIP_HIT_SOUND)
         w_pri_in = 2'd2;
      else if (sound_signal == MONSTER_HIT_SOUND)
         w_pri_in = 2'd1;
      w_trig = (sound_signal != r_prev) &&
               (w_pri_in != 2'd0) &&
               (w_pri_in >= r_pri);
      w_nidx     = r_note + 2'd1;
      w_f0_freq  = lut_freq(w_pri_in, 2'd0);
      w_f0_units = lut_units(w_pri_in, 2'd0);
      w_cur_last = lut_last(r_pri, r_note);
      w_nx_freq  = lut_freq(r_pri, w_nidx);
      w_nx_units = lut_units(r_pri, w_nidx);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_prev      <= 4'd0;
         r_cnt       <= '0;
         r_pri       <= 2'd0;
         r_note      <= 2'd0;
         tone_freq   <= 10'd0;
         tone_enable <= 1'b0;
         busy        <= 1'b0;
      end else begin
         r_prev <= sound_signal;
         if (w_trig) begin
            // A trigger wins over any expiry on the same cycle
            r_state     <= S_PLAY;
            r_pri       <= w_pri_in;
            r_note      <= 2'd0;
            r_cnt       <= ticks(w_f0_units);
            tone_freq   <= w_f0_freq;
            tone_enable <= 1'b1;
            busy        <= 1'b1;
         end else begin
            case (r_state)
               S_PLAY: begin
                  if (r_cnt == CW'(1)) begin
                     tone_freq   <= 10'd0;
                     tone_enable <= 1'b0;
                     if (w_cur_last) begin
                        r_state <= S_IDLE;
                        r_pri   <= 2'd0;
                        r_note  <= 2'd0;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                     end else begin
                        r_state <= S_GAP;
                        r_cnt   <= CW'(GAP_TICKS);
                     end
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
               S_GAP: begin
                  if (r_cnt == CW'(1)) begin
                     r_state     <= S_PLAY;
                     r_note      <= w_nidx;
                     r_cnt       <= ticks(w_nx_units);
                     tone_freq   <= w_nx_freq;
                     tone_enable <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt - CW'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sound_player.sv
// Bench for sound_player: per-cycle expected outputs queued as stimulus
// is applied, then popped and compared one cycle at a time.
module tb_sound_player;

   typedef struct packed {
      logic [9:0] f;
      logic       en;
      logic       b;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [3:0] sound_signal;
   logic [9:0] tone_freq;
   logic       tone_enable;
   logic       busy;

   int   checks;
   int   errors;
   exp_t sb[$];
   exp_t e;
   exp_t g;

   sound_player #(
      .NOTE_TICKS(4),
      .GAP_TICKS (2)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sound_signal(sound_signal),
      .tone_freq   (tone_freq),
      .tone_enable (tone_enable),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic push_tone(input int f, input int n);
      repeat (n) sb.push_back({10'(f), 1'b1, 1'b1});
   endtask

   task automatic push_gap(input int n);
      repeat (n) sb.push_back({10'd0, 1'b0, 1'b1});
   endtask

   task automatic push_idle(input int n);
      repeat (n) sb.push_back({10'd0, 1'b0, 1'b0});
   endtask

   task automatic push_monster();
      push_tone(440, 8);
      push_gap(2);
      push_tone(330, 8);
   endtask

   task automatic push_spaceship();
      push_tone(220, 12);
      push_gap(2);
      push_tone(165, 12);
      push_gap(2);
      push_tone(110, 16);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sound_signal = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      g = {tone_freq, tone_enable, busy};
      checks++;
      if (g !== 12'd0) begin
         errors++;
         $display("FAIL reset got f=%0d en=%0b b=%0b exp 0/0/0",
                  g.f, g.en, g.b);
      end
      reset = 1'b0;
      push_idle(2);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
         e = sb.pop_front();
         g = {tone_freq, tone_enable, busy};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL reset_idle cyc %0d got f=%0d en=%0b b=%0b exp f=%0d en=%0b b=%0b",
                     i, g.f, g.en, g.b, e.f, e.en, e.b);
         end
      end
   endtask

   task automatic test_monster();
      sound_signal = 4'b0001;
      push_monster();
      push_idle(3);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
         e = sb.pop_front();
         g = {tone_freq, tone_enable, busy};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL monster cyc %0d got f=%0d en=%0b b=%0b exp f=%0d en=%0b b=%0b",
                     i, g.f, g.en, g.b, e.f, e.en, e.b);
         end
         if (i == 0) sound_signal = 4'd0;
      end
   endtask

   task automatic test_spaceship();
      sound_signal = 4'b1101;
      push_spaceship();
      push_idle(3);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
         e = sb.pop_front();
         g = {tone_freq, tone_enable, busy};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL spaceship cyc %0d got f=%0d en=%0b b=%0b exp f=%0d en=%0b b=%0b",
                     i, g.f, g.en, g.b, e.f, e.en, e.b);
         end
         if (i == 0) sound_signal = 4'd0;
      end
   endtask

   task automatic test_preempt();
      sound_signal = 4'b0001;
      push_tone(440, 5);
      push_spaceship();
      push_idle(3);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
         e = sb.pop_front();
         g = {tone_freq, tone_enable, busy};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL preempt cyc %0d got f=%0d en=%0b b=%0b exp f=%0d en=%0b b=%0b",
                     i, g.f, g.en, g.b, e.f, e.en, e.b);
         end
         case (i)
            0:       sound_signal = 4'd0;
            4:       sound_signal = 4'b1101;
            5:       sound_signal = 4'd0;
            20:      sound_signal = 4'b0001;
            21:      sound_signal = 4'd0;
            default: ;
         endcase
      end
   endtask

   task automatic test_level_unknown();
      sound_signal = 4'b0001;
      push_monster();
      push_idle(82);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
         e = sb.pop_front();
         g = {tone_freq, tone_enable, busy};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL level cyc %0d got f=%0d en=%0b b=%0b exp f=%0d en=%0b b=%0b",
                     i, g.f, g.en, g.b, e.f, e.en, e.b);
         end
         if (i == 99) sound_signal = 4'b0111;
      end
      push_idle(5);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
         e = sb.pop_front();
         g = {tone_freq, tone_enable, busy};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL unknown cyc %0d got f=%0d en=%0b b=%0b exp f=%0d en=%0b b=%0b",
                     i, g.f, g.en, g.b, e.f, e.en, e.b);
         end
      end
      sound_signal = 4'b0001;
      push_monster();
      push_idle(3);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
         e = sb.pop_front();
         g = {tone_freq, tone_enable, busy};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL unk_to_mon cyc %0d got f=%0d en=%0b b=%0b exp f=%0d en=%0b b=%0b",
                     i, g.f, g.en, g.b, e.f, e.en, e.b);
         end
         if (i == 0) sound_signal = 4'd0;
      end
   endtask

   task automatic test_restart();
      sound_signal = 4'b0001;
      push_tone(440, 8);
      push_gap(2);
      push_tone(330, 3);
      push_monster();
      push_idle(3);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
         e = sb.pop_front();
         g = {tone_freq, tone_enable, busy};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL restart cyc %0d got f=%0d en=%0b b=%0b exp f=%0d en=%0b b=%0b",
                     i, g.f, g.en, g.b, e.f, e.en, e.b);
         end
         case (i)
            0:       sound_signal = 4'd0;
            12:      sound_signal = 4'b0001;
            13:      sound_signal = 4'd0;
            default: ;
         endcase
      end
   endtask

   task automatic test_reset_mid();
      sound_signal = 4'b0001;
      push_tone(440, 8);
      push_gap(1);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
         e = sb.pop_front();
         g = {tone_freq, tone_enable, busy};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL rst_mid_pre cyc %0d got f=%0d en=%0b b=%0b exp f=%0d en=%0b b=%0b",
                     i, g.f, g.en, g.b, e.f, e.en, e.b);
         end
      end
      #2;
      reset = 1'b1;
      #1;
      g = {tone_freq, tone_enable, busy};
      checks++;
      if (g !== 12'd0) begin
         errors++;
         $display("FAIL rst_mid_async got f=%0d en=%0b b=%0b exp 0/0/0",
                  g.f, g.en, g.b);
      end
      @(posedge clk);
      #1;
      g = {tone_freq, tone_enable, busy};
      checks++;
      if (g !== 12'd0) begin
         errors++;
         $display("FAIL rst_mid_hold got f=%0d en=%0b b=%0b exp 0/0/0",
                  g.f, g.en, g.b);
      end
      reset = 1'b0;
      push_monster();
      push_idle(3);
      for (int i = 0; sb.size() > 0; i++) begin
         @(posedge clk);
         #1;
         e = sb.pop_front();
         g = {tone_freq, tone_enable, busy};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL rst_mid_replay cyc %0d got f=%0d en=%0b b=%0b exp f=%0d en=%0b b=%0b",
                     i, g.f, g.en, g.b, e.f, e.en, e.b);
         end
      end
      sound_signal = 4'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      sound_signal = 4'd0;
      test_reset();
      test_monster();
      test_spaceship();
      test_preempt();
      test_level_unknown();
      test_restart();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
